loudness_frame_ctrl: RTL and testbench

- Frame-level controller for the loudness path.
- Takes the streamed FFT bin output (valid plus sop/eop framing) and gates a configurable bin band into a squared-magnitude accumulator.
- Clears the accumulator at frame start and reports one loudness value per frame over a valid/ready handshake.
- Derives a hysteretic is_loud flag for downstream display/control logic.

---
 rtl/loudness_pkg.sv | 25 ++
 rtl/fft_bin_power.sv | 49 ++++
 rtl/loudness_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_loudness_frame_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loudness_pkg.sv
// rtl/loudness_pkg.sv - shared types and constants for the loudness frame controller
// Purpose: FSM state encoding, default geometry, accumulator width helper and
// the pipeline flush length used by the controller.
// Ports: none (package).
package loudness_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam int DEF_W     = 16;
  localparam int DEF_NBINS = 1024;

  // Cycles spent in DRAIN after the eop edge before the result is registered.
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  // Two squared W-bit terms summed over NBINS bins can never exceed this width.
  function automatic int acc_width(input int w, input int nbins);
    return 2 * w + $clog2(nbins);
  endfunction

endpackage

// File: rtl/fft_bin_power.sv
// rtl/fft_bin_power.sv - two-stage squared-magnitude accumulator
// Purpose: stage 1 registers re^2 and im^2, stage 2 adds their sum into acc.
// Ports:
//   clk, reset (async active-low)
//   clear     - zero the accumulator; wins over a pending stage-2 add
//   in_valid  - current beat belongs to the band and must be accumulated
//   re_in/im_in - signed FFT bin components
//   acc       - running band power
module fft_bin_power #(
  parameter int W     = 16,
  parameter int ACC_W = 42
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  input  logic signed [W-1:0] re_in,
  input  logic signed [W-1:0] im_in,
  output logic [ACC_W-1:0]    acc
);

  logic signed [2*W-1:0] sq_re_q, sq_im_q;
  logic                  v1_q;
  logic [ACC_W-1:0]      acc_q;
  logic [2*W:0]          pwr_sum;

  // Squares are never negative, so the sum is safely treated as unsigned.
  assign pwr_sum = {1'b0, sq_re_q} + {1'b0, sq_im_q};
  assign acc     = acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_re_q <= '0;
      sq_im_q <= '0;
      v1_q    <= 1'b0;
      acc_q   <= '0;
    end else begin
      sq_re_q <= re_in * re_in;
      sq_im_q <= im_in * im_in;
      v1_q    <= in_valid;
      // A clear drops whatever stage 1 still holds from the previous frame.
      if (clear)
        acc_q <= '0;
      else if (v1_q)
        acc_q <= acc_q + ACC_W'(pwr_sum);
    end
  end

endmodule

// File: rtl/loudness_frame_ctrl.sv
// rtl/loudness_frame_ctrl.sv - frame controller gating an FFT bin band into a power accumulator
// Purpose: tracks sop/eop framing, feeds in-band bins to fft_bin_power, reports
// one loudness value per frame over valid/ready and maintains a hysteretic flag.
// Ports:
//   clk, reset (async active-low), enable (sampled on sop beats)
//   cfg_bin_lo/hi, cfg_thresh_on/off - band and hysteresis configuration
//   fft_valid/sop/eop, fft_real/imag - streamed FFT bins, no backpressure
//   loudness, loud_valid, loud_ready - per-frame result handshake
//   is_loud, frame_err, busy, overrun_cnt - status
module loudness_frame_ctrl
  import loudness_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int NBINS = DEF_NBINS,
  parameter int BIN_W = $clog2(NBINS),
  parameter int ACC_W = acc_width(W, NBINS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [BIN_W-1:0]    cfg_bin_lo,
  input  logic [BIN_W-1:0]    cfg_bin_hi,
  input  logic [ACC_W-1:0]    cfg_thresh_on,
  input  logic [ACC_W-1:0]    cfg_thresh_off,
  input  logic                fft_valid,
  input  logic                fft_sop,
  input  logic                fft_eop,
  input  logic signed [W-1:0] fft_real,
  input  logic signed [W-1:0] fft_imag,
  output logic [ACC_W-1:0]    loudness,
  output logic                loud_valid,
  input  logic                loud_ready,
  output logic                is_loud,
  output logic                frame_err,
  output logic                busy,
  output logic [7:0]          overrun_cnt
);

  // idx carries one extra bit so a beat past the last bin is distinguishable.
  localparam logic [BIN_W:0] IDX_ONE  = (BIN_W + 1)'(1);
  localparam logic [BIN_W:0] LAST_IDX = (BIN_W + 1)'(NBINS - 1);
  localparam logic [BIN_W:0] PAST_END = (BIN_W + 1)'(NBINS);

  state_e           state_q;
  logic [BIN_W-1:0] lo_q, hi_q;
  logic [BIN_W:0]   idx_q;
  logic [1:0]       drain_q;
  logic [ACC_W-1:0] loudness_q;
  logic             loud_valid_q, is_loud_q, frame_err_q;
  logic [7:0]       overrun_q;
  logic [ACC_W-1:0] acc;

  logic             beat_sop;
  logic             start_d;
  logic [BIN_W:0]   beat_idx_d, band_lo_d, band_hi_d;
  logic             in_band_d;

  assign beat_sop = fft_valid & fft_sop;

  // The opening beat uses the live config, since the latch happens on that edge.
  always_comb begin
    start_d    = beat_sop & (((state_q == IDLE) & enable) | (state_q == ACCUM));
    beat_idx_d = start_d ? '0 : idx_q;
    band_lo_d  = {1'b0, start_d ? cfg_bin_lo : lo_q};
    band_hi_d  = {1'b0, start_d ? cfg_bin_hi : hi_q};
    in_band_d  = fft_valid & (start_d | (state_q == ACCUM)) &
                 (beat_idx_d >= band_lo_d) & (beat_idx_d <= band_hi_d);
  end

  fft_bin_power #(.W(W), .ACC_W(ACC_W)) u_power (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_d),
    .in_valid (in_band_d),
    .re_in    (fft_real),
    .im_in    (fft_imag),
    .acc      (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      idx_q        <= '0;
      drain_q      <= '0;
      loudness_q   <= '0;
      loud_valid_q <= 1'b0;
      is_loud_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            lo_q  <= cfg_bin_lo;
            hi_q  <= cfg_bin_hi;
            idx_q <= IDX_ONE;
            // sop and eop together is a one-beat frame: always short.
            if (fft_eop) frame_err_q <= 1'b1;
            else         state_q     <= ACCUM;
          end
        end
        ACCUM: begin
          if (fft_valid) begin
            if (fft_sop) begin
              frame_err_q <= 1'b1;
              lo_q        <= cfg_bin_lo;
              hi_q        <= cfg_bin_hi;
              idx_q       <= IDX_ONE;
              if (fft_eop) state_q <= IDLE;
            end else if (idx_q == PAST_END) begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
            end else if (fft_eop) begin
              if (idx_q == LAST_IDX) begin
                state_q <= DRAIN;
                drain_q <= '0;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= IDLE;
              end
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
        end
        DRAIN: begin
          if (beat_sop && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
          if (drain_q == DRAIN_CYCLES) begin
            state_q      <= REPORT;
            loudness_q   <= acc;
            loud_valid_q <= 1'b1;
            if (!is_loud_q && acc >= cfg_thresh_on)
              is_loud_q <= 1'b1;
            else if (is_loud_q && acc < cfg_thresh_off)
              is_loud_q <= 1'b0;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        REPORT: begin
          if (beat_sop && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
          if (loud_ready) begin
            state_q      <= IDLE;
            loud_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign loudness    = loudness_q;
  assign loud_valid  = loud_valid_q;
  assign is_loud     = is_loud_q;
  assign frame_err   = frame_err_q;
  assign overrun_cnt = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_loudness_frame_ctrl.sv
// tb/tb_loudness_frame_ctrl.sv - scoreboard bench for loudness_frame_ctrl
module tb_loudness_frame_ctrl;
  localparam int W     = 16;
  localparam int NBINS = 8;
  localparam int BIN_W = 3;
  localparam int ACC_W = 35;

  typedef struct {
    logic [ACC_W-1:0] loud;
    logic             flag;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b1;
  logic [BIN_W-1:0]    cfg_bin_lo = '0, cfg_bin_hi = '0;
  logic [ACC_W-1:0]    th_on = '0, th_off = '0;
  logic                fft_valid = 1'b0, fft_sop = 1'b0, fft_eop = 1'b0;
  logic signed [W-1:0] fft_real = '0, fft_imag = '0;
  logic [ACC_W-1:0]    loudness;
  logic                loud_valid, is_loud, frame_err, busy;
  logic                loud_ready = 1'b1;
  logic [7:0]          overrun_cnt;

  loudness_frame_ctrl #(.W(W), .NBINS(NBINS)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .enable         (enable),
    .cfg_bin_lo     (cfg_bin_lo),
    .cfg_bin_hi     (cfg_bin_hi),
    .cfg_thresh_on  (th_on),
    .cfg_thresh_off (th_off),
    .fft_valid      (fft_valid),
    .fft_sop        (fft_sop),
    .fft_eop        (fft_eop),
    .fft_real       (fft_real),
    .fft_imag       (fft_imag),
    .loudness       (loudness),
    .loud_valid     (loud_valid),
    .loud_ready     (loud_ready),
    .is_loud        (is_loud),
    .frame_err      (frame_err),
    .busy           (busy),
    .overrun_cnt    (overrun_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  exp_t sb_q[$];
  int   checks = 0, errors = 0;
  int   err_seen = 0, err_exp = 0, eop_edge = 0;
  logic prev_valid = 1'b0, expect_low = 1'b0;
  logic signed [W-1:0] fr_re[NBINS], fr_im[NBINS];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push_exp(input longint l, input logic f);
    exp_t e;
    e.loud = ACC_W'(l);
    e.flag = f;
    sb_q.push_back(e);
  endtask

  // Drives nb beats from fr_re/fr_im; eop on the last beat when with_eop.
  task automatic send_frame(input int nb, input bit mark, input bit with_eop);
    for (int i = 0; i < nb; i++) begin
      fft_valid = 1'b1;
      fft_sop   = (i == 0);
      fft_eop   = with_eop && (i == nb - 1);
      fft_real  = fr_re[i];
      fft_imag  = fr_im[i];
      @(posedge clk); #1;
      if (mark && fft_eop) eop_edge = edge_n;
    end
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_eop   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 50 && busy; i++) begin
      @(posedge clk); #1;
    end
    check(name, busy, 0);
  endtask

  task automatic fill(input int re_v, input int im_v, input bit ramp);
    for (int i = 0; i < NBINS; i++) begin
      fr_re[i] = ramp ? W'(i) : W'(re_v);
      fr_im[i] = ramp ? W'(i) : W'(im_v);
    end
  endtask

  // Monitor: compares presented results against the scoreboard head.
  always @(negedge clk) begin
    if (expect_low) begin
      check("valid_drop_after_accept", loud_valid, 0);
      expect_low = 1'b0;
    end
    if (loud_valid && !prev_valid)
      check("eop_to_valid_latency", edge_n - eop_edge, 3);
    if (loud_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_report", 1, 0);
      end else begin
        check("loudness", loudness, sb_q[0].loud);
        check("is_loud", is_loud, sb_q[0].flag);
        if (loud_ready) begin
          void'(sb_q.pop_front());
          expect_low = 1'b1;
        end
      end
    end
    if (frame_err) err_seen++;
    prev_valid = loud_valid;
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_loudness", loudness, 0);
    check("rst_valid", loud_valid, 0);
    check("rst_is_loud", is_loud, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    th_on = 35'd1000;
    th_off = 35'd500;

    // All bins 1+0j, full band.
    fill(1, 0, 0);
    cfg_bin_lo = 3'd0; cfg_bin_hi = 3'd7;
    push_exp(8, 1'b0);
    send_frame(8, 1, 1);
    wait_idle("idle_full_band");

    // Ramp bins, band 2..3 then empty band 5..4.
    fill(0, 0, 1);
    cfg_bin_lo = 3'd2; cfg_bin_hi = 3'd3;
    push_exp(26, 1'b0);
    send_frame(8, 1, 1);
    wait_idle("idle_band_2_3");
    cfg_bin_lo = 3'd5; cfg_bin_hi = 3'd4;
    push_exp(0, 1'b0);
    send_frame(8, 1, 1);
    wait_idle("idle_empty_band");

    // Frame with enable low is ignored entirely.
    enable = 1'b0;
    send_frame(8, 0, 1);
    check("disabled_busy", busy, 0);
    enable = 1'b1;

    // Hysteresis: powers 120, 70, 40 with on=100 off=50.
    th_on = 35'd100;
    th_off = 35'd50;
    cfg_bin_lo = 3'd0; cfg_bin_hi = 3'd1;
    fill(100, 100, 0);
    fr_re[0] = 10; fr_im[0] = 2; fr_re[1] = 4; fr_im[1] = 0;
    push_exp(120, 1'b1);
    send_frame(8, 1, 1);
    wait_idle("idle_pwr120");
    fr_re[0] = 6; fr_im[0] = 5; fr_re[1] = 3; fr_im[1] = 0;
    push_exp(70, 1'b1);
    send_frame(8, 1, 1);
    wait_idle("idle_pwr70");
    fr_re[0] = 6; fr_im[0] = 2; fr_re[1] = 0; fr_im[1] = 0;
    push_exp(40, 1'b0);
    send_frame(8, 1, 1);
    wait_idle("idle_pwr40");

    // Full-scale negative inputs: no wrap.
    fill(-32768, -32768, 0);
    cfg_bin_lo = 3'd0; cfg_bin_hi = 3'd7;
    push_exp(64'd17179869184, 1'b1);
    send_frame(8, 1, 1);
    wait_idle("idle_full_scale");

    // Stalled consumer: two more frames are dropped and counted.
    fill(1, 0, 0);
    loud_ready = 1'b0;
    push_exp(8, 1'b0);
    send_frame(8, 1, 1);
    for (int i = 0; i < 20 && !loud_valid; i++) begin
      @(posedge clk); #1;
    end
    check("stall_valid_seen", loud_valid, 1);
    send_frame(8, 0, 1);
    send_frame(8, 0, 1);
    check("overrun_cnt", overrun_cnt, 2);
    check("stall_valid_held", loud_valid, 1);
    check("stall_busy", busy, 1);
    loud_ready = 1'b1;
    wait_idle("idle_after_stall");
    fill(0, 0, 1);
    cfg_bin_lo = 3'd2; cfg_bin_hi = 3'd3;
    push_exp(26, 1'b0);
    send_frame(8, 1, 1);
    wait_idle("idle_post_overrun");

    // Short frame: eop at idx 5.
    err_exp++;
    send_frame(6, 0, 1);
    check("short_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;

    // Reset in the middle of a frame.
    send_frame(4, 0, 0);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_loudness", loudness, 0);
    check("mid_rst_valid", loud_valid, 0);
    check("mid_rst_is_loud", is_loud, 0);
    check("mid_rst_frame_err", frame_err, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    check("scoreboard_drained", sb_q.size(), 0);
    check("frame_err_pulses", err_seen, err_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
